// File: rtl/ibuf_bank_resp.sv
// ibuf_bank_resp: banked input pixel buffer.
//
// The buffer has POY banks. Each bank holds ROWS*COLS pixels.
// The loader fills it over a valid/ready stream. The order is column
// fastest, then bank, then row. The last beat of a block raises
// blkend for one cycle, and from then on reads are legal.
// The data router reads it with a fixed two-cycle latency.
// blk_release hands the block back: the buffer drains its read pipeline
// and then accepts a new fill.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   wr_valid/wr_ready/wr_data   loader pixel stream
//   blkend         one-cycle pulse when the block is fully loaded
//   blk_release    one-cycle pulse: block consumed, start refill
//   rpsel          read mode: 00 RR all banks, 01 BR one bank,
//                  10 RP single pixel to lane 0, 11 NE no read
//   bank/row/col   read address (only the low log2(COLS) bits of col are used)
//   rd_valid       result present this cycle
//   rd_lane_vld    per-lane valid mask
//   rd_data        lane i at bits [i*DW +: DW]
//   rd_err         illegal-read flag
//
// Optional feature macro: IBUF_RDERR_EN
//   When it is defined, rd_err is a sticky flag. It is set by any illegal read.
//   When it is not defined, rd_err is tied to 0 and illegal reads are dropped silently.
module ibuf_bank_resp #(
  parameter int DW   = 8,
  parameter int POY  = 3,
  parameter int ROWS = 4,
  parameter int COLS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DW-1:0]     wr_data,
  output logic              blkend,
  input  logic              blk_release,
  input  logic [1:0]        rpsel,
  input  logic [1:0]        bank,
  input  logic [1:0]        row,
  input  logic [27:0]       col,
  output logic              rd_valid,
  output logic [POY-1:0]    rd_lane_vld,
  output logic [POY*DW-1:0] rd_data,
  output logic              rd_err
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW    = (POY > 1) ? $clog2(POY) : 1;
  localparam int AW    = RW + CW;
  localparam int DEPTH = ROWS * COLS;

  localparam logic [1:0] MODE_RR = 2'b00;
  localparam logic [1:0] MODE_BR = 2'b01;
  localparam logic [1:0] MODE_RP = 2'b10;
  localparam logic [1:0] MODE_NE = 2'b11;

  typedef enum logic [1:0] {FILL, LOADED, DRAIN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wc, wc_next;
  logic [BW-1:0] wb, wb_next;
  logic [RW-1:0] wrow, wrow_next;
  logic          drain_cnt, drain_cnt_next;
  logic          wr_fire, last_beat;

  logic [DW-1:0] mem [POY][DEPTH];

  // Only the low column bits address a row. The upper bits are don't-care.
  logic unused_col_bits;
  assign unused_col_bits = &{1'b0, col[27:CW]};

  // Fill counters and block state machine.
  always_comb begin
    state_next     = state;
    wc_next        = wc;
    wb_next        = wb;
    wrow_next      = wrow;
    drain_cnt_next = drain_cnt;
    wr_ready       = 1'b0;
    wr_fire        = 1'b0;
    last_beat      = 1'b0;
    case (state)
      FILL: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          wr_fire = 1'b1;
          if (wc == CW'(COLS - 1)) begin
            wc_next = '0;
            if (wb == BW'(POY - 1)) begin
              wb_next = '0;
              if (wrow == RW'(ROWS - 1)) begin
                wrow_next  = '0;
                last_beat  = 1'b1;
                state_next = LOADED;
              end else begin
                wrow_next = wrow + 1'b1;
              end
            end else begin
              wb_next = wb + 1'b1;
            end
          end else begin
            wc_next = wc + 1'b1;
          end
        end
      end
      LOADED: begin
        if (blk_release) begin
          state_next     = DRAIN;
          drain_cnt_next = 1'b0;
        end
      end
      DRAIN: begin
        // Hold for two cycles, so that a read accepted in the
        // release cycle completes before refill writes start.
        if (drain_cnt) begin
          state_next     = FILL;
          drain_cnt_next = 1'b0;
        end else begin
          drain_cnt_next = 1'b1;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      wc        <= '0;
      wb        <= '0;
      wrow      <= '0;
      drain_cnt <= 1'b0;
      blkend    <= 1'b0;
    end else begin
      state     <= state_next;
      wc        <= wc_next;
      wb        <= wb_next;
      wrow      <= wrow_next;
      drain_cnt <= drain_cnt_next;
      blkend    <= last_beat;
    end
  end

  // Pixel storage. Its contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wb][{wrow, wc}] <= wr_data;
    end
  end

  // Read request legality is judged against the state at the sampling edge.
  // A read in the same cycle as the final fill beat therefore sees FILL.
  logic rd_req, bank_ok, rd_legal;
  assign rd_req   = (rpsel != MODE_NE);
  assign bank_ok  = (rpsel == MODE_RR) || ({30'd0, bank} < 32'(POY));
  assign rd_legal = rd_req && (state == LOADED) && bank_ok;

  // Stage 1: capture the request.
  logic          s1_valid;
  logic [1:0]    s1_mode;
  logic [BW-1:0] s1_bank;
  logic [AW-1:0] s1_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_NE;
      s1_bank  <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= rd_legal;
      if (rd_legal) begin
        s1_mode <= rpsel;
        s1_bank <= bank[BW-1:0];
        s1_addr <= {row[RW-1:0], col[CW-1:0]};
      end
    end
  end

  // Stage 2: read the banks into the lane output registers.
  logic [POY-1:0] lane_mask;
  always_comb begin
    lane_mask = '0;
    case (s1_mode)
      MODE_RR: lane_mask = '1;
      MODE_BR: lane_mask = {1'b1, {(POY-1){1'b0}}};
      MODE_RP: lane_mask = POY'(1);
      default: lane_mask = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid    <= 1'b0;
      rd_lane_vld <= '0;
    end else begin
      rd_valid    <= s1_valid;
      rd_lane_vld <= s1_valid ? lane_mask : '0;
    end
  end

  // Each lane register updates only when its lane is targeted.
  // Untouched lanes keep their previous value.
  genvar gi;
  generate
    for (gi = 0; gi < POY; gi++) begin : g_lane
      logic [DW-1:0] lane_q;
      logic          lane_rr, lane_sel;
      assign lane_rr  = (s1_mode == MODE_RR);
      assign lane_sel = ((gi == POY - 1) && (s1_mode == MODE_BR)) ||
                        ((gi == 0) && (s1_mode == MODE_RP));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_q <= '0;
        end else if (s1_valid) begin
          if (lane_rr) begin
            lane_q <= mem[gi][s1_addr];
          end else if (lane_sel) begin
            lane_q <= mem[s1_bank][s1_addr];
          end
        end
      end
      assign rd_data[gi*DW +: DW] = lane_q;
    end
  endgenerate

`ifdef IBUF_RDERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_err <= 1'b0;
    end else if (rd_req && !rd_legal) begin
      rd_err <= 1'b1;
    end
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule
